// File: rtl/mult_pkg.sv
// Shared defaults and state encoding for the sequential Booth multiplier.
package mult_pkg;

  localparam int MBITS_DEF = 12;
  localparam int NBITS_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then
// arithmetic right shift of the combined {A,Q,q-1} register.
module booth_step #(
  parameter int MBITS = 12,
  parameter int NBITS = 8
) (
  input  logic [MBITS:0]   a,
  input  logic [NBITS-1:0] q,
  input  logic             q_m1,
  input  logic [MBITS:0]   m,
  output logic [MBITS:0]   a_next,
  output logic [NBITS-1:0] q_next,
  output logic             q_m1_next
);

  logic [MBITS:0] sum;

  // A carries one guard bit so A-M cannot overflow when M is the most negative value
  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_next    = {sum[MBITS], sum[MBITS:1]};
    q_next    = {sum[0], q[NBITS-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/mult.sv
// Sequential signed multiplier: one Booth step per clock, result held in
// prod from the edge that ends RUN until the next operation completes.
//
//   state | meaning
//   IDLE  | waiting for start; prod holds the last result
//   RUN   | NBITS Booth steps in progress; start ignored
module mult
  import mult_pkg::*;
#(
  parameter int MBITS = MBITS_DEF,
  parameter int NBITS = NBITS_DEF
) (
  output logic [MBITS+NBITS-1:0] prod,
  input  logic [MBITS-1:0]       mpd,
  input  logic [NBITS-1:0]       mpr,
  input  logic                   clk,
  output logic                   busy,
  input  logic                   start,
  input  logic                   reset
);

  localparam int CW = $clog2(NBITS + 1);

  state_t           state, state_nxt;
  logic [MBITS:0]   a_q, m_q, a_step;
  logic [NBITS-1:0] q_q, q_step;
  logic             qm1_q, qm1_step;
  logic [CW-1:0]    cnt_q;
  logic             load, step, last;

  booth_step #(
    .MBITS(MBITS),
    .NBITS(NBITS)
  ) u_step (
    .a        (a_q),
    .q        (q_q),
    .q_m1     (qm1_q),
    .m        (m_q),
    .a_next   (a_step),
    .q_next   (q_step),
    .q_m1_next(qm1_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      prod  <= '0;
    end else if (load) begin
      m_q   <= {mpd[MBITS-1], mpd};
      a_q   <= '0;
      q_q   <= mpr;
      qm1_q <= 1'b0;
      cnt_q <= CW'(NBITS);
    end else if (step) begin
      a_q   <= a_step;
      q_q   <= q_step;
      qm1_q <= qm1_step;
      cnt_q <= cnt_q - CW'(1);
      // the guard bit of A is dropped; the low MBITS+NBITS bits are exact
      if (last) prod <= {a_step[MBITS-1:0], q_step};
    end
  end

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: literal test-plan cases plus randomized
// start/operand traffic compared every cycle against a behavioural model.
module tb_mult;

  localparam int MB = 12;
  localparam int NB = 8;
  localparam int PW = MB + NB;

  logic [PW-1:0] prod;
  logic [MB-1:0] mpd;
  logic [NB-1:0] mpr;
  logic          clk = 1'b0;
  logic          busy;
  logic          start = 1'b0;
  logic          reset = 1'b0;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  mult #(.MBITS(MB), .NBITS(NB)) dut (
    .prod (prod),
    .mpd  (mpd),
    .mpr  (mpr),
    .clk  (clk),
    .busy (busy),
    .start(start),
    .reset(reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a product is the truncated integer product, delivered
  // NB edges after the capturing edge; starts are ignored while one is pending.
  int            rem_m  = 0;
  logic [PW-1:0] pend_m = '0;
  logic [PW-1:0] prod_m = '0;
  longint        full_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_m  = 0;
      prod_m = '0;
    end else if (rem_m > 0) begin
      rem_m--;
      if (rem_m == 0) prod_m = pend_m;
    end else if (start) begin
      full_m = longint'($signed(mpd)) * longint'($signed(mpr));
      pend_m = full_m[PW-1:0];
      rem_m  = NB;
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("busy_model", longint'(busy), longint'(rem_m > 0));
      chk("prod_model", longint'(prod), longint'(prod_m));
    end
  end

  // Pulse start with the given operands, optionally pulse start again with
  // other operands mid-RUN, then check the busy length and the product.
  task automatic do_op(input string name, input logic [MB-1:0] a, input logic [NB-1:0] b,
                       input logic [PW-1:0] exp, input int glitch_at);
    int n;
    bit done;
    @(negedge clk); #1;
    mpd = a; mpr = b; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    mpd = MB'($urandom); mpr = NB'($urandom);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!busy) begin
        done = 1'b1;
      end else begin
        n++;
        start = (n == glitch_at);
        if (start) begin
          mpd = 12'd5; mpr = 8'hFD;
        end
        @(negedge clk); #1;
      end
    end
    start = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout busy still high after 20 cycles", name);
    end
    chk({name, "_busy_len"}, n, NB);
    chk({name, "_prod"}, longint'(prod), longint'(exp));
  endtask

  initial begin
    mpd = '0;
    mpr = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_prod", longint'(prod), 0);
    armed = 1'b1;

    do_op("max_pos",     12'd2047, 8'd127, 20'h3F781, -1);
    do_op("neg_pos",     12'h801,  8'd127, 20'hC087F, -1);
    do_op("neg_neg",     12'h801,  8'h81,  20'h3F781, -1);
    do_op("min_min",     12'h800,  8'h80,  20'h40000, -1);
    do_op("zero",        12'd0,    8'hFF,  20'h00000, -1);
    do_op("start_ignored", 12'd2047, 8'd127, 20'h3F781, 3);

    // abort: reset at the fourth RUN cycle clears busy and prod at once
    @(negedge clk); #1;
    mpd = 12'd2047; mpr = 8'd127; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_prod", longint'(prod), 0);
    @(negedge clk); #1 reset = 1'b0;
    do_op("after_abort", 12'd5, 8'hFD, 20'hFFFF1, -1);

    // random traffic: level start (including held-high back-to-back runs)
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) == 0) || (c >= 1500 && c < 1600);
      if ($urandom_range(0, 7) == 0) begin
        mpd = 12'h800; mpr = 8'h80;
      end else begin
        mpd = MB'($urandom); mpr = NB'($urandom);
      end
    end
    @(negedge clk); #1 start = 1'b0;
    repeat (12) @(negedge clk);
    armed = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
